npn4_canonicalizer: RTL and testbench
=====================================

Name: npn4_canonicalizer

Overview:
- Sequential classifier for 4-input Boolean functions, the inverse direction of the per-class exact MIG netlists.
- Takes an arbitrary 16-bit truth table and finds its NPN class representative, defined as the minimum truth table over all transforms.
- Also reports the first transform that produces that representative.
- Downstream logic uses the representative to select the stored exact netlist, and uses the transform to rewire the netlist's inputs and output.

Parameters:
- OUT_NEG_EN, 1: 1 = full NPN (768 transforms); 0 = NP only (384 transforms, output never negated).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  truth table offered
- in_ready  out  1  block idle, can accept
- in_tt  in  16  truth table; bit i = f(x3 x2 x1 x0 = i), x0 is the LSB of i
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_tt  out  16  canonical (minimum) truth table
- out_perm  out  8  permutation; bits [2m+1:2m] = perm[m]
- out_neg  out  4  input negation mask n
- out_oneg  out  1  output negation o
- out_idx  out  10  transform index k of the reported transform

Behaviour:
- Transform definition: g(x) = o ^ f(y), where y_m = x_perm[m] ^ n_m.
  - Transformed table bit i = o ^ in_tt[j], where bit m of j = (bit perm[m] of i) ^ n_m.
- Enumeration order:
  - p = 0..23 indexes permutations of (0,1,2,3) in lexicographic order; p=0 is identity, p=18 is (3,0,1,2), p=23 is (3,2,1,0).
  - OUT_NEG_EN=1: k = p*32 + n*2 + o, k = 0..767.
  - OUT_NEG_EN=0: k = p*16 + n, o = 0, k = 0..383.
  - N = number of transforms (768 or 384).
- States: IDLE, SCAN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch in_tt, set k=0, initialise best to 0xFFFF with the "first" flag set, go to SCAN.
- SCAN:
  - in_ready=0; in_valid is ignored.
  - Evaluates exactly one transform per cycle, k = 0..N-1.
  - Updates best only when the candidate is strictly less than best, or when k=0. Ties keep the earliest k.
  - After k=N-1, go to DONE.
- DONE:
  - out_valid=1; outputs registered and held stable until out_ready.
  - On out_valid&out_ready: go to IDLE.
- Latency: if accept occurs in cycle 0, out_valid rises in cycle N+1 (769 for full NPN).
- After the output handshake, in_ready=1 in the next cycle. No overlap of input acceptance and output handshake.
- Reset values:
  - state=IDLE, so in_ready=1.
  - out_valid=0, out_tt=0, out_perm=0, out_neg=0, out_oneg=0, out_idx=0.
- rst asserted in any state, including mid-SCAN or DONE awaiting out_ready: abort and return to reset values on the next edge; the aborted result is never presented.
- in_tt changes while busy have no effect; the latched copy is used.
- The permutation for index p is generated by a counter plus a lookup table or decode. The decoded perm must always be a valid permutation: no repeated entries.

Test Plan:
- in_tt=0x0000 -> out_tt=0x0000, out_idx=0, out_perm=0xE4, out_neg=0, out_oneg=0; out_valid 769 cycles after accept.
- in_tt=0xFFFF -> out_tt=0x0000, out_idx=1, out_oneg=1, out_neg=0, out_perm=0xE4. With OUT_NEG_EN=0 -> out_tt=0xFFFF, out_idx=0, out_valid after 385 cycles.
- in_tt=0x8000 (AND4) -> out_tt=0x0001, out_idx=30, out_neg=0xF, out_oneg=0, out_perm=0xE4.
- in_tt=0xAAAA (x0) -> out_tt=0x00FF, out_idx=577, out_perm=0x93 (perm = 3,0,1,2), out_neg=0, out_oneg=1.
- Backpressure: hold out_ready=0 for 20 cycles in DONE and toggle in_valid/in_tt -> outputs stable, in_ready=0; after handshake, in_ready=1 on the next cycle and a new table is accepted.
- Assert rst for 1 cycle at k≈300 -> next cycle out_valid=0, in_ready=1, all outputs zero; a fresh 0xAAAA run still returns idx 577.

Source files
------------

// File: rtl/npn4_canonicalizer.sv
// npn4_canonicalizer
// ------------------
// Sequential NPN classifier for 4-input Boolean functions. A truth table is
// latched, then every transform (input permutation, input negation and,
// optionally, output negation) is evaluated at one transform per cycle. The
// numerically smallest transformed table is the class representative. The
// first transform index that produces it is reported together with its
// decoded permutation and negation fields.
//
// Handshake (both sides): a transfer happens on a rising edge where
// valid && ready are both high. in_ready is high only in IDLE. out_valid is
// high only in DONE, and the outputs hold steady until out_ready is seen.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   truth table offered
//   in_ready   block idle, can accept
//   in_tt      truth table, bit i = f(x3 x2 x1 x0 = i)
//   out_valid  result available
//   out_ready  consumer accepts result
//   out_tt     canonical (minimum) truth table
//   out_perm   permutation, bits [2m+1:2m] = perm[m]
//   out_neg    input negation mask
//   out_oneg   output negation
//   out_idx    transform index of the reported transform
module npn4_canonicalizer #(
  parameter bit OUT_NEG_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_tt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_tt,
  output logic [7:0]  out_perm,
  output logic [3:0]  out_neg,
  output logic        out_oneg,
  output logic [9:0]  out_idx
);

  localparam int         NUM_XFORMS = OUT_NEG_EN ? 768 : 384;
  localparam logic [9:0] K_LAST     = 10'(NUM_XFORMS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [7:0] perm;
    logic [3:0] neg;
    logic       oneg;
  } xform_t;

  // Permutations of (0,1,2,3) in lexicographic order. Each entry is packed
  // as {perm[3], perm[2], perm[1], perm[0]}. Out-of-range indices fall back
  // to the identity so the decode is always a valid permutation.
  function automatic logic [7:0] perm_lut(input logic [4:0] p);
    logic [7:0] r;
    case (p)
      5'd0:    r = {2'd3, 2'd2, 2'd1, 2'd0};
      5'd1:    r = {2'd2, 2'd3, 2'd1, 2'd0};
      5'd2:    r = {2'd3, 2'd1, 2'd2, 2'd0};
      5'd3:    r = {2'd1, 2'd3, 2'd2, 2'd0};
      5'd4:    r = {2'd2, 2'd1, 2'd3, 2'd0};
      5'd5:    r = {2'd1, 2'd2, 2'd3, 2'd0};
      5'd6:    r = {2'd3, 2'd2, 2'd0, 2'd1};
      5'd7:    r = {2'd2, 2'd3, 2'd0, 2'd1};
      5'd8:    r = {2'd3, 2'd0, 2'd2, 2'd1};
      5'd9:    r = {2'd0, 2'd3, 2'd2, 2'd1};
      5'd10:   r = {2'd2, 2'd0, 2'd3, 2'd1};
      5'd11:   r = {2'd0, 2'd2, 2'd3, 2'd1};
      5'd12:   r = {2'd3, 2'd1, 2'd0, 2'd2};
      5'd13:   r = {2'd1, 2'd3, 2'd0, 2'd2};
      5'd14:   r = {2'd3, 2'd0, 2'd1, 2'd2};
      5'd15:   r = {2'd0, 2'd3, 2'd1, 2'd2};
      5'd16:   r = {2'd1, 2'd0, 2'd3, 2'd2};
      5'd17:   r = {2'd0, 2'd1, 2'd3, 2'd2};
      5'd18:   r = {2'd2, 2'd1, 2'd0, 2'd3};
      5'd19:   r = {2'd1, 2'd2, 2'd0, 2'd3};
      5'd20:   r = {2'd2, 2'd0, 2'd1, 2'd3};
      5'd21:   r = {2'd0, 2'd2, 2'd1, 2'd3};
      5'd22:   r = {2'd1, 2'd0, 2'd2, 2'd3};
      5'd23:   r = {2'd0, 2'd1, 2'd2, 2'd3};
      default: r = {2'd3, 2'd2, 2'd1, 2'd0};
    endcase
    return r;
  endfunction

  // Split a transform index into its fields. With output negation enabled
  // the index is p*32 + n*2 + o, otherwise p*16 + n with o fixed at 0.
  function automatic xform_t decode_idx(input logic [9:0] idx);
    xform_t x;
    if (OUT_NEG_EN) begin
      x.perm = perm_lut(idx[9:5]);
      x.neg  = idx[4:1];
      x.oneg = idx[0];
    end else begin
      x.perm = perm_lut(idx[8:4]);
      x.neg  = idx[3:0];
      x.oneg = 1'b0;
    end
    return x;
  endfunction

  // g(i) = o ^ f(j), where j[m] = i[perm[m]] ^ n[m].
  function automatic logic [15:0] apply_xform(input logic [15:0] tt,
                                               input xform_t     x);
    logic [15:0] r;
    logic [3:0]  iv;
    logic [3:0]  j;
    r  = '0;
    iv = '0;
    j  = '0;
    for (int i = 0; i < 16; i++) begin
      iv = 4'(i);
      for (int m = 0; m < 4; m++) begin
        j[m] = iv[x.perm[2*m +: 2]] ^ x.neg[m];
      end
      r[i] = x.oneg ^ tt[j];
    end
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [9:0]  k_q;
  logic [15:0] tt_q;
  logic [15:0] best_tt_q;
  logic [9:0]  best_idx_q;
  logic        first_q;
  logic        out_valid_q;

  xform_t      cur_x;
  xform_t      fin_x;
  logic [15:0] cand_tt;
  logic        take;
  logic [15:0] nbest_tt;
  logic [9:0]  nbest_idx;

  // Candidate for the current index and the running minimum including it.
  // The first candidate always wins. Later ones must be strictly smaller,
  // so ties keep the earliest index.
  always_comb begin
    cur_x     = decode_idx(k_q);
    cand_tt   = apply_xform(tt_q, cur_x);
    take      = first_q || (cand_tt < best_tt_q);
    nbest_tt  = take ? cand_tt : best_tt_q;
    nbest_idx = take ? k_q     : best_idx_q;
    fin_x     = decode_idx(nbest_idx);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)        state_d = SCAN;
      SCAN:    if (k_q == K_LAST)   state_d = DONE;
      DONE:    if (out_ready)       state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      tt_q        <= '0;
      best_tt_q   <= 16'hFFFF;
      best_idx_q  <= '0;
      first_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_tt      <= '0;
      out_perm    <= '0;
      out_neg     <= '0;
      out_oneg    <= 1'b0;
      out_idx     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            tt_q       <= in_tt;
            k_q        <= '0;
            best_tt_q  <= 16'hFFFF;
            best_idx_q <= '0;
            first_q    <= 1'b1;
          end
        end
        SCAN: begin
          best_tt_q  <= nbest_tt;
          best_idx_q <= nbest_idx;
          first_q    <= 1'b0;
          k_q        <= k_q + 10'd1;
          if (k_q == K_LAST) begin
            // Result is captured straight from the final comparison so
            // the last candidate is included without an extra cycle.
            out_valid_q <= 1'b1;
            out_tt      <= nbest_tt;
            out_idx     <= nbest_idx;
            out_perm    <= fin_x.perm;
            out_neg     <= fin_x.neg;
            out_oneg    <= fin_x.oneg;
          end
        end
        DONE: begin
          if (out_ready) out_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_npn4_canonicalizer.sv
module tb_npn4_canonicalizer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance a: full NPN. Instance b: NP only.
  logic        in_valid_a = 1'b0, in_valid_b = 1'b0;
  logic [15:0] in_tt_a = '0,      in_tt_b = '0;
  logic        out_ready_a = 1'b0, out_ready_b = 1'b0;
  logic        in_ready_a, in_ready_b;
  logic        out_valid_a, out_valid_b;
  logic [15:0] out_tt_a, out_tt_b;
  logic [7:0]  out_perm_a, out_perm_b;
  logic [3:0]  out_neg_a, out_neg_b;
  logic        out_oneg_a, out_oneg_b;
  logic [9:0]  out_idx_a, out_idx_b;

  npn4_canonicalizer #(.OUT_NEG_EN(1'b1)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_tt(in_tt_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_tt(out_tt_a), .out_perm(out_perm_a), .out_neg(out_neg_a),
    .out_oneg(out_oneg_a), .out_idx(out_idx_a)
  );

  npn4_canonicalizer #(.OUT_NEG_EN(1'b0)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_tt(in_tt_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_tt(out_tt_b), .out_perm(out_perm_b), .out_neg(out_neg_b),
    .out_oneg(out_oneg_b), .out_idx(out_idx_b)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic [15:0] tt;
    logic [7:0]  perm;
    logic [3:0]  neg;
    logic        oneg;
    logic [9:0]  idx;
  } res_t;

  typedef struct {
    bit          sel;      // 0 = full NPN instance, 1 = NP-only instance
    logic [15:0] tt;
    logic [15:0] e_tt;
    logic [7:0]  e_perm;
    logic [3:0]  e_neg;
    logic        e_oneg;
    logic [9:0]  e_idx;
    int          e_cyc;    // cycle of out_valid when accept is cycle 0
  } vec_t;

  // ---------------- driver ----------------
  // Offers tt to the chosen instance, waits for the result, and optionally
  // completes the output handshake. Returns with the time at posedge+1.
  task automatic run_one(input bit sel, input logic [15:0] tt,
                         input bit do_ack, output res_t r, output int cyc,
                         output bit busy_seen, output bit timed_out);
    @(negedge clk);
    if (sel) begin in_valid_b = 1'b1; in_tt_b = tt; end
    else     begin in_valid_a = 1'b1; in_tt_a = tt; end
    @(posedge clk);
    #1;
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    busy_seen = sel ? !in_ready_b : !in_ready_a;
    cyc = 1;
    timed_out = 1'b1;
    for (int t = 0; t < 2000; t++) begin
      if (sel ? out_valid_b : out_valid_a) begin
        timed_out = 1'b0;
        break;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    r.tt   = sel ? out_tt_b   : out_tt_a;
    r.perm = sel ? out_perm_b : out_perm_a;
    r.neg  = sel ? out_neg_b  : out_neg_a;
    r.oneg = sel ? out_oneg_b : out_oneg_a;
    r.idx  = sel ? out_idx_b  : out_idx_a;
    if (timed_out) check("result_timeout", 32'd1, 32'd0);
    if (do_ack) begin
      if (sel) out_ready_b = 1'b1; else out_ready_a = 1'b1;
      @(posedge clk);
      #1;
      out_ready_a = 1'b0;
      out_ready_b = 1'b0;
    end
  endtask

  vec_t vecs[8];

  initial begin
    res_t r;
    int   cyc;
    bit   busy;
    bit   tmo;

    vecs[0] = '{1'b0, 16'h0000, 16'h0000, 8'hE4, 4'h0, 1'b0, 10'd0,   769};
    vecs[1] = '{1'b0, 16'hFFFF, 16'h0000, 8'hE4, 4'h0, 1'b1, 10'd1,   769};
    vecs[2] = '{1'b0, 16'h8000, 16'h0001, 8'hE4, 4'hF, 1'b0, 10'd30,  769};
    vecs[3] = '{1'b0, 16'hAAAA, 16'h00FF, 8'h93, 4'h0, 1'b1, 10'd577, 769};
    vecs[4] = '{1'b0, 16'h0002, 16'h0001, 8'hE4, 4'h1, 1'b0, 10'd2,   769};
    vecs[5] = '{1'b0, 16'h7FFF, 16'h0001, 8'hE4, 4'hF, 1'b1, 10'd31,  769};
    vecs[6] = '{1'b1, 16'hFFFF, 16'hFFFF, 8'hE4, 4'h0, 1'b0, 10'd0,   385};
    vecs[7] = '{1'b1, 16'hAAAA, 16'h00FF, 8'h93, 4'h1, 1'b0, 10'd289, 385};

    // Reset and check reset values.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready",  32'(in_ready_a),  32'd1);
    check("rst_out_valid", 32'(out_valid_a), 32'd0);
    check("rst_outputs",
          {out_tt_a, out_perm_a, out_neg_a, out_oneg_a, 3'b000},
          32'd0);
    check("rst_idx", 32'(out_idx_a), 32'd0);
    check("rst_in_ready_np", 32'(in_ready_b), 32'd1);

    // Table-driven vectors.
    for (int v = 0; v < 8; v++) exp_q.push_back(vecs[v].e_tt);
    for (int v = 0; v < 8; v++) begin
      logic [15:0] e_tt;
      run_one(vecs[v].sel, vecs[v].tt, 1'b1, r, cyc, busy, tmo);
      e_tt = exp_q.pop_front();
      check($sformatf("v%0d_tt", v),   32'(r.tt),   32'(e_tt));
      check($sformatf("v%0d_perm", v), 32'(r.perm), 32'(vecs[v].e_perm));
      check($sformatf("v%0d_neg", v),  32'(r.neg),  32'(vecs[v].e_neg));
      check($sformatf("v%0d_oneg", v), 32'(r.oneg), 32'(vecs[v].e_oneg));
      check($sformatf("v%0d_idx", v),  32'(r.idx),  32'(vecs[v].e_idx));
      check($sformatf("v%0d_latency", v), 32'(cyc), 32'(vecs[v].e_cyc));
      check($sformatf("v%0d_busy", v), 32'(busy), 32'd1);
      check($sformatf("v%0d_ready_after_ack", v),
            32'(vecs[v].sel ? in_ready_b : in_ready_a), 32'd1);
    end

    // Backpressure: hold the result while the input side is noisy.
    run_one(1'b0, 16'h8000, 1'b0, r, cyc, busy, tmo);
    check("bp_tt", 32'(r.tt), 32'h0001);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      in_valid_a = 1'($urandom_range(0, 1));
      in_tt_a    = 16'($urandom_range(0, 65535));
      @(posedge clk);
      #1;
      check($sformatf("bp_hold_%0d", c),
            {out_valid_a, in_ready_a, out_tt_a, out_idx_a, 4'h0},
            {1'b1, 1'b0, 16'h0001, 10'd30, 4'h0});
    end
    in_valid_a  = 1'b0;
    out_ready_a = 1'b1;
    @(posedge clk);
    #1 out_ready_a = 1'b0;
    check("bp_ready_after_ack", 32'(in_ready_a),  32'd1);
    check("bp_valid_dropped",   32'(out_valid_a), 32'd0);
    run_one(1'b0, 16'hAAAA, 1'b1, r, cyc, busy, tmo);
    check("bp_next_idx", 32'(r.idx), 32'd577);
    check("bp_next_tt",  32'(r.tt),  32'h00FF);

    // Reset in the middle of a scan.
    @(negedge clk);
    in_valid_a = 1'b1;
    in_tt_a    = 16'h8000;
    @(posedge clk);
    #1 in_valid_a = 1'b0;
    repeat (300) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("mid_rst_out_valid", 32'(out_valid_a), 32'd0);
    check("mid_rst_in_ready",  32'(in_ready_a),  32'd1);
    check("mid_rst_outputs",
          {out_tt_a, out_perm_a, out_neg_a, out_oneg_a, 3'b000}, 32'd0);
    check("mid_rst_idx", 32'(out_idx_a), 32'd0);
    run_one(1'b0, 16'hAAAA, 1'b1, r, cyc, busy, tmo);
    check("post_rst_idx",     32'(r.idx),  32'd577);
    check("post_rst_perm",    32'(r.perm), 32'h93);
    check("post_rst_latency", 32'(cyc),    32'd769);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
